// File: rtl/mon_mem_resp_pkg.sv
// Shared definitions for the monitor memory responder: FSM encoding, target
// select constants and the out-of-range read pattern.
package mon_mem_resp_pkg;

    typedef logic [2:0] state_t;

    localparam state_t S_IDLE = 3'd0;
    localparam state_t S_WR   = 3'd1;
    localparam state_t S_RD   = 3'd2;
    localparam state_t S_RCAP = 3'd3;
    localparam state_t S_DONE = 3'd4;
    localparam state_t S_REL  = 3'd5;

    localparam logic        TGT_IMEM = 1'b1;
    localparam logic [31:0] BAD_DATA = 32'hDEADBEEF;

    // Read-latency counter width; covers RD_LAT = 1..3.
    localparam int unsigned CNT_W = 2;

    // Byte address to RAM word index, dropping the byte offset and wrapping.
    function automatic logic [31:0] word_of(input logic [31:0] adr);
        return adr >> 2;
    endfunction

endpackage

// File: rtl/mon_rd_lat_cnt.sv
// RAM read-latency down-counter. zero_c is high on the cycle whose decrement
// brings the count to zero, so the read state lasts exactly RD_LAT cycles.
module mon_rd_lat_cnt
    import mon_mem_resp_pkg::*;
#(
    parameter int unsigned RD_LAT = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic dec,
    output logic zero_c
);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= CNT_W'(RD_LAT);
        end else if (dec && (cnt != '0)) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    assign zero_c = (cnt <= CNT_W'(1));

endmodule

// File: rtl/mon_mem_resp.sv
// Memory-side responder for the UART monitor: waits for the CPU to halt, then
// performs one word read or write on the instruction or data RAM per request.
// Optional address range checking is enabled with MON_RANGE_CHK_EN.
module mon_mem_resp
    import mon_mem_resp_pkg::*;
#(
    parameter int unsigned IWIDTH = 14,
    parameter int unsigned DWIDTH = 14,
    parameter int unsigned RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              u_read_req,
    input  logic              u_read_w,
    input  logic [31:0]       u_read_adr,
    output logic              read_valid,
    output logic [31:0]       read_data,
    input  logic              u_write_req,
    input  logic              u_write_w,
    input  logic [31:0]       u_write_adr,
    input  logic [31:0]       u_write_data,
    output logic              write_finish,
`ifdef MON_RANGE_CHK_EN
    output logic              range_err,
`endif
    input  logic              cpu_run,
    output logic              mon_busy,
    output logic [IWIDTH-1:0] imem_adr,
    output logic              imem_we,
    output logic [31:0]       imem_wdata,
    input  logic [31:0]       imem_rdata,
    output logic [DWIDTH-1:0] dmem_adr,
    output logic              dmem_we,
    output logic [31:0]       dmem_wdata,
    input  logic [31:0]       dmem_rdata
);

    state_t      state;
    state_t      state_next;
    logic        grant_wr;
    logic        grant_rd;
    logic        sel_w;
    logic [31:0] sel_adr;
    logic        sel_oor;
    logic        tgt;
    logic        oor;
    logic        lat_zero_c;

    logic              read_valid_d;
    logic [31:0]       read_data_d;
    logic              write_finish_d;
    logic              mon_busy_d;
    logic [IWIDTH-1:0] imem_adr_d;
    logic              imem_we_d;
    logic [31:0]       imem_wdata_d;
    logic [DWIDTH-1:0] dmem_adr_d;
    logic              dmem_we_d;
    logic [31:0]       dmem_wdata_d;

    // Byte offsets (and, without range checking, upper bits) are don't-care.
    logic unused_adr;
    assign unused_adr = ^{u_read_adr, u_write_adr};

    assign sel_w   = grant_wr ? u_write_w   : u_read_w;
    assign sel_adr = grant_wr ? u_write_adr : u_read_adr;

`ifdef MON_RANGE_CHK_EN
    assign sel_oor = (sel_w == TGT_IMEM) ? ((sel_adr >> (IWIDTH + 2)) != 32'd0)
                                         : ((sel_adr >> (DWIDTH + 2)) != 32'd0);
`else
    assign sel_oor = 1'b0;
`endif

    mon_rd_lat_cnt #(
        .RD_LAT (RD_LAT)
    ) u_lat (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (grant_rd),
        .dec    (state == S_RD),
        .zero_c (lat_zero_c)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state; a write wins over a simultaneous read
    always_comb begin
        state_next = state;
        grant_wr   = 1'b0;
        grant_rd   = 1'b0;
        case (state)
            S_IDLE: begin
                if (!cpu_run) begin
                    if (u_write_req) begin
                        grant_wr   = 1'b1;
                        state_next = S_WR;
                    end else if (u_read_req) begin
                        grant_rd   = 1'b1;
                        state_next = S_RD;
                    end
                end
            end
            S_WR:   state_next = S_DONE;
            S_RD:   if (lat_zero_c) state_next = S_RCAP;
            S_RCAP: state_next = S_DONE;
            S_DONE: state_next = S_REL;
            S_REL:  if (!u_write_req && !u_read_req) state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Output next values, registered below
    always_comb begin
        imem_adr_d     = imem_adr;
        dmem_adr_d     = dmem_adr;
        imem_wdata_d   = imem_wdata;
        dmem_wdata_d   = dmem_wdata;
        imem_we_d      = 1'b0;
        dmem_we_d      = 1'b0;
        read_data_d    = read_data;
        read_valid_d   = (state == S_RCAP);
        write_finish_d = (state == S_WR);
        mon_busy_d     = (state_next != S_IDLE);

        if (grant_wr || grant_rd) begin
            if (sel_w == TGT_IMEM) begin
                imem_adr_d = IWIDTH'(word_of(sel_adr));
            end else begin
                dmem_adr_d = DWIDTH'(word_of(sel_adr));
            end
        end

        if (grant_wr) begin
            if (sel_w == TGT_IMEM) begin
                imem_wdata_d = u_write_data;
                imem_we_d    = !sel_oor;
            end else begin
                dmem_wdata_d = u_write_data;
                dmem_we_d    = !sel_oor;
            end
        end

        if (state == S_RCAP) begin
            if (oor) begin
                read_data_d = BAD_DATA;
            end else begin
                read_data_d = (tgt == TGT_IMEM) ? imem_rdata : dmem_rdata;
            end
        end
    end

    // Output and per-access registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tgt          <= 1'b0;
            oor          <= 1'b0;
            read_valid   <= 1'b0;
            read_data    <= '0;
            write_finish <= 1'b0;
            mon_busy     <= 1'b0;
            imem_adr     <= '0;
            imem_we      <= 1'b0;
            imem_wdata   <= '0;
            dmem_adr     <= '0;
            dmem_we      <= 1'b0;
            dmem_wdata   <= '0;
        end else begin
            if (grant_wr || grant_rd) begin
                tgt <= sel_w;
                oor <= sel_oor;
            end
            read_valid   <= read_valid_d;
            read_data    <= read_data_d;
            write_finish <= write_finish_d;
            mon_busy     <= mon_busy_d;
            imem_adr     <= imem_adr_d;
            imem_we      <= imem_we_d;
            imem_wdata   <= imem_wdata_d;
            dmem_adr     <= dmem_adr_d;
            dmem_we      <= dmem_we_d;
            dmem_wdata   <= dmem_wdata_d;
        end
    end

`ifdef MON_RANGE_CHK_EN
    // Sticky out-of-range flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            range_err <= 1'b0;
        end else if ((grant_wr || grant_rd) && sel_oor) begin
            range_err <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_mon_mem_resp.sv
// Self-checking bench for mon_mem_resp: behavioural RAMs plus a word-level
// memory model, randomized read/write traffic and directed corner scenarios.
module tb_mon_mem_resp;

    localparam int unsigned IW = 14;
    localparam int unsigned DW = 14;
    localparam int unsigned RL = 1;

    logic          clk;
    logic          rst_n;
    logic          u_read_req;
    logic          u_read_w;
    logic [31:0]   u_read_adr;
    logic          read_valid;
    logic [31:0]   read_data;
    logic          u_write_req;
    logic          u_write_w;
    logic [31:0]   u_write_adr;
    logic [31:0]   u_write_data;
    logic          write_finish;
    logic          cpu_run;
    logic          mon_busy;
    logic [IW-1:0] imem_adr;
    logic          imem_we;
    logic [31:0]   imem_wdata;
    logic [31:0]   imem_rdata;
    logic [DW-1:0] dmem_adr;
    logic          dmem_we;
    logic [31:0]   dmem_wdata;
    logic [31:0]   dmem_rdata;
`ifdef MON_RANGE_CHK_EN
    logic          range_err;
`endif

    int total;
    int bad;
    logic [31:0] last_rd;
    logic [31:0] exp_i [int];
    logic [31:0] exp_d [int];

    mon_mem_resp #(.IWIDTH(IW), .DWIDTH(DW), .RD_LAT(RL)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .u_read_req   (u_read_req),
        .u_read_w     (u_read_w),
        .u_read_adr   (u_read_adr),
        .read_valid   (read_valid),
        .read_data    (read_data),
        .u_write_req  (u_write_req),
        .u_write_w    (u_write_w),
        .u_write_adr  (u_write_adr),
        .u_write_data (u_write_data),
        .write_finish (write_finish),
`ifdef MON_RANGE_CHK_EN
        .range_err    (range_err),
`endif
        .cpu_run      (cpu_run),
        .mon_busy     (mon_busy),
        .imem_adr     (imem_adr),
        .imem_we      (imem_we),
        .imem_wdata   (imem_wdata),
        .imem_rdata   (imem_rdata),
        .dmem_adr     (dmem_adr),
        .dmem_we      (dmem_we),
        .dmem_wdata   (dmem_wdata),
        .dmem_rdata   (dmem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Power-up contents of both RAMs
    function automatic logic [31:0] pat(input logic w, input int unsigned idx);
        return 32'hA500_0000 ^ (w ? 32'h0080_0000 : 32'h0) ^ (idx * 32'h0000_9E37);
    endfunction

    // Behavioural RAMs with RL-cycle read latency from a registered address
    logic [31:0] iarr [0:(1<<IW)-1];
    logic [31:0] darr [0:(1<<DW)-1];
    bit          iwr  [0:(1<<IW)-1];
    bit          dwr  [0:(1<<DW)-1];
    logic [31:0] ipipe [RL];
    logic [31:0] dpipe [RL];

    always @(posedge clk) begin
        if (imem_we) begin
            iarr[imem_adr] <= imem_wdata;
            iwr[imem_adr]  <= 1'b1;
        end
        if (dmem_we) begin
            darr[dmem_adr] <= dmem_wdata;
            dwr[dmem_adr]  <= 1'b1;
        end
        ipipe[0] <= iwr[imem_adr] ? iarr[imem_adr] : pat(1'b1, 32'(imem_adr));
        dpipe[0] <= dwr[dmem_adr] ? darr[dmem_adr] : pat(1'b0, 32'(dmem_adr));
        for (int i = 1; i < RL; i++) begin
            ipipe[i] <= ipipe[i-1];
            dpipe[i] <= dpipe[i-1];
        end
    end
    assign imem_rdata = ipipe[RL-1];
    assign dmem_rdata = dpipe[RL-1];

    function automatic int unsigned widx_of(input logic w, input logic [31:0] adr);
        return w ? ((adr / 4) % (1 << IW)) : ((adr / 4) % (1 << DW));
    endfunction

    function automatic logic [31:0] model_rd(input logic w, input int unsigned idx);
        if (w) return exp_i.exists(idx) ? exp_i[idx] : pat(1'b1, idx);
        return exp_d.exists(idx) ? exp_d[idx] : pat(1'b0, idx);
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic w, input logic [31:0] adr, input logic [31:0] data,
                            input bit oor);
        int unsigned ix;
        ix = widx_of(w, adr);
        u_write_w = w; u_write_adr = adr; u_write_data = data; u_write_req = 1'b1;
        tick;
        total++;
        if ((w ? imem_we : dmem_we) !== !oor) begin
            bad++; $display("FAIL wr_we: got %0b want %0b adr=%h", w ? imem_we : dmem_we, !oor, adr);
        end
        total++;
        if ((w ? dmem_we : imem_we) !== 1'b0) begin
            bad++; $display("FAIL wr_other_we: got 1 want 0 adr=%h", adr);
        end
        if (!oor) begin
            total++;
            if ((w ? 32'(imem_adr) : 32'(dmem_adr)) !== ix ||
                (w ? imem_wdata : dmem_wdata) !== data) begin
                bad++;
                $display("FAIL wr_adr_data: got %0d/%h want %0d/%h", w ? 32'(imem_adr) : 32'(dmem_adr),
                         w ? imem_wdata : dmem_wdata, ix, data);
            end
        end
        tick;
        total++;
        if ({write_finish, imem_we, dmem_we, mon_busy} !== 4'b1001 || read_data !== last_rd) begin
            bad++;
            $display("FAIL wr_finish: got fin/iwe/dwe/busy=%b rd=%h want 1001 rd=%h",
                     {write_finish, imem_we, dmem_we, mon_busy}, read_data, last_rd);
        end
        if (!oor) begin
            if (w) exp_i[ix] = data; else exp_d[ix] = data;
        end
        u_write_req = 1'b0;
        tick;
        tick;
        total++;
        if ({write_finish, mon_busy} !== 2'b00) begin
            bad++; $display("FAIL wr_release: got fin/busy=%b want 00", {write_finish, mon_busy});
        end
    endtask

    task automatic do_read(input logic w, input logic [31:0] adr, input bit oor);
        logic [31:0] exp;
        int cyc;
        bit stray;
        exp = oor ? 32'hDEAD_BEEF : model_rd(w, widx_of(w, adr));
        u_read_w = w; u_read_adr = adr; u_read_req = 1'b1;
        cyc = 0; stray = 0;
        do begin
            tick;
            cyc++;
            if (imem_we || dmem_we || write_finish) stray = 1;
        end while (!read_valid && cyc < 20);
        total++;
        if (!read_valid || cyc != 2 + RL || stray) begin
            bad++; $display("FAIL rd_latency: got %0d cycles valid=%0b stray=%0b want %0d", cyc, read_valid, stray, 2 + RL);
        end
        total++;
        if (read_data !== exp) begin
            bad++; $display("FAIL rd_data: got %h want %h adr=%h w=%0b", read_data, exp, adr, w);
        end
        last_rd = exp;
        u_read_req = 1'b0;
        tick;
        total++;
        if (read_valid !== 1'b0 || mon_busy !== 1'b1 || read_data !== exp) begin
            bad++; $display("FAIL rd_after: got valid=%0b busy=%0b data=%h want 0 1 %h", read_valid, mon_busy, read_data, exp);
        end
        tick;
        total++;
        if (mon_busy !== 1'b0) begin
            bad++; $display("FAIL rd_release: got busy=%0b want 0", mon_busy);
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        #1;
        total++;
        if ({read_valid, write_finish, mon_busy, imem_we, dmem_we} !== 5'b0 || read_data !== 32'h0 ||
            32'(imem_adr) !== 32'h0 || 32'(dmem_adr) !== 32'h0 || imem_wdata !== 32'h0 || dmem_wdata !== 32'h0) begin
            bad++; $display("FAIL reset_outputs: got flags=%b rd=%h want 0", {read_valid, write_finish, mon_busy, imem_we, dmem_we}, read_data);
        end
        repeat (3) tick;
        rst_n = 1'b1;
        repeat (2) tick;
        total++;
        if ({read_valid, write_finish, mon_busy, imem_we, dmem_we} !== 5'b0) begin
            bad++; $display("FAIL reset_idle: got %b want 00000", {read_valid, write_finish, mon_busy, imem_we, dmem_we});
        end
`ifdef MON_RANGE_CHK_EN
        total++;
        if (range_err !== 1'b0) begin
            bad++; $display("FAIL reset_range_err: got %0b want 0", range_err);
        end
`endif
    endtask

    task automatic test_write_read_dmem;
        do_write(1'b0, 32'h0000_0010, 32'h1234_5678, 1'b0);
        do_read(1'b0, 32'h0000_0010, 1'b0);
        do_write(1'b1, 32'h0000_0008, 32'h0BAD_F00D, 1'b0);
        do_read(1'b1, 32'h0000_000B, 1'b0);
    endtask

    task automatic test_random;
        for (int n = 0; n < 40; n++) begin
            logic w;
            int unsigned idx;
            logic [31:0] adr;
            w   = 1'($urandom_range(0, 1));
            idx = ($urandom_range(0, 7) == 0) ? ((1 << IW) - 1) : $urandom_range(0, 15);
            adr = (idx << 2) | 32'($urandom_range(0, 3));
`ifndef MON_RANGE_CHK_EN
            adr = adr | ($urandom << (IW + 2));
`endif
            if ($urandom_range(0, 1) == 1) do_write(w, adr, $urandom, 1'b0);
            else do_read(w, adr, 1'b0);
            repeat ($urandom_range(0, 2)) tick;
        end
    endtask

    task automatic test_cpu_run_hold;
        bit viol;
        cpu_run = 1'b1;
        u_write_w = 1'b0; u_write_adr = 32'h0000_0020; u_write_data = 32'h5A5A_0001; u_write_req = 1'b1;
        u_read_w = 1'b1; u_read_adr = 32'h0000_0008; u_read_req = 1'b1;
        viol = 0;
        repeat (5) begin
            tick;
            if (mon_busy || imem_we || dmem_we || read_valid || write_finish) viol = 1;
        end
        total++;
        if (viol) begin
            bad++; $display("FAIL cpu_run_hold: got activity while cpu_run=1 want none");
        end
        cpu_run = 1'b0;
        tick;
        total++;
        if (dmem_we !== 1'b1 || 32'(dmem_adr) !== 32'd8 || imem_we !== 1'b0) begin
            bad++; $display("FAIL write_first: got dwe=%0b dadr=%0d iwe=%0b want 1 8 0", dmem_we, dmem_adr, imem_we);
        end
        exp_d[8] = 32'h5A5A_0001;
        tick;
        total++;
        if (write_finish !== 1'b1 || read_valid !== 1'b0) begin
            bad++; $display("FAIL write_first_fin: got fin=%0b rv=%0b want 1 0", write_finish, read_valid);
        end
        u_write_req = 1'b0;
        viol = 0;
        repeat (3) begin
            tick;
            if (!mon_busy || read_valid || imem_we || dmem_we) viol = 1;
        end
        total++;
        if (viol) begin
            bad++; $display("FAIL read_held_off: got read activity while read level held want none");
        end
        u_read_req = 1'b0;
        tick;
        total++;
        if (mon_busy !== 1'b0) begin
            bad++; $display("FAIL cpu_run_release: got busy=%0b want 0", mon_busy);
        end
        do_read(1'b1, 32'h0000_0008, 1'b0);
        do_read(1'b0, 32'h0000_0020, 1'b0);
    endtask

    task automatic test_held_request;
        int pulses;
        int cyc;
        bit busy_drop;
        u_read_w = 1'b0; u_read_adr = 32'h0000_0010; u_read_req = 1'b1;
        pulses = 0; cyc = 0; busy_drop = 0;
        do begin
            tick; cyc++;
            if (read_valid) pulses++;
        end while (pulses == 0 && cyc < 20);
        total++;
        if (read_data !== model_rd(1'b0, 4)) begin
            bad++; $display("FAIL held_data: got %h want %h", read_data, model_rd(1'b0, 4));
        end
        last_rd = model_rd(1'b0, 4);
        repeat (10) begin
            tick;
            if (read_valid) pulses++;
            if (!mon_busy) busy_drop = 1;
        end
        total++;
        if (pulses != 1 || busy_drop) begin
            bad++; $display("FAIL held_single: got pulses=%0d busy_drop=%0b want 1 0", pulses, busy_drop);
        end
        u_read_req = 1'b0;
        tick;
        total++;
        if (mon_busy !== 1'b0 || read_valid !== 1'b0) begin
            bad++; $display("FAIL held_release: got busy=%0b rv=%0b want 0 0", mon_busy, read_valid);
        end
    endtask

    task automatic test_reset_mid_op;
        bit seen;
        u_read_w = 1'b1; u_read_adr = 32'h0000_0004; u_read_req = 1'b1;
        tick;
        #2 rst_n = 1'b0;
        #1;
        total++;
        if ({read_valid, write_finish, mon_busy, imem_we, dmem_we} !== 5'b0 || read_data !== 32'h0) begin
            bad++; $display("FAIL rst_mid_read: got flags=%b rd=%h want 0", {read_valid, write_finish, mon_busy, imem_we, dmem_we}, read_data);
        end
        last_rd = 32'h0;
        u_read_req = 1'b0;
        tick;
        rst_n = 1'b1;
        seen = 0;
        repeat (6) begin
            tick;
            if (read_valid || mon_busy) seen = 1;
        end
        total++;
        if (seen) begin
            bad++; $display("FAIL rst_mid_read_after: got completion or busy after reset want none");
        end
        u_write_w = 1'b1; u_write_adr = 32'h0000_0040; u_write_data = 32'h7777_0000; u_write_req = 1'b1;
        tick;
        #2 rst_n = 1'b0;
        #1;
        total++;
        if (imem_we !== 1'b0 || write_finish !== 1'b0) begin
            bad++; $display("FAIL rst_mid_write: got iwe=%0b fin=%0b want 0 0", imem_we, write_finish);
        end
        u_write_req = 1'b0;
        tick;
        rst_n = 1'b1;
        repeat (2) tick;
        do_read(1'b1, 32'h0000_0040, 1'b0);
    endtask

`ifdef MON_RANGE_CHK_EN
    task automatic test_range;
        do_write(1'b0, 32'h0010_0000, 32'hCAFE_F00D, 1'b1);
        total++;
        if (range_err !== 1'b1) begin
            bad++; $display("FAIL range_err_set: got %0b want 1", range_err);
        end
        do_read(1'b0, 32'h0010_0000, 1'b1);
        do_read(1'b0, 32'h0000_0000, 1'b0);
        total++;
        if (range_err !== 1'b1) begin
            bad++; $display("FAIL range_err_sticky: got %0b want 1", range_err);
        end
    endtask
`else
    task automatic test_wrap;
        do_write(1'b0, 32'h0010_0010, 32'hCAFE_F00D, 1'b0);
        do_read(1'b0, 32'h0000_0010, 1'b0);
        do_write(1'b1, 32'hFFFF_FFFC, 32'h0102_0304, 1'b0);
        do_read(1'b1, 32'h0000_FFFC, 1'b0);
    endtask
`endif

    initial begin
        total = 0; bad = 0; last_rd = 32'h0;
        rst_n = 1'b0; cpu_run = 1'b0;
        u_read_req = 1'b0; u_read_w = 1'b0; u_read_adr = '0;
        u_write_req = 1'b0; u_write_w = 1'b0; u_write_adr = '0; u_write_data = '0;
        test_reset;
        test_write_read_dmem;
        test_cpu_run_hold;
        test_held_request;
        test_random;
`ifdef MON_RANGE_CHK_EN
        test_range;
`else
        test_wrap;
`endif
        test_reset_mid_op;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
